cache_wb_ctrl: RTL



---
 rtl/cache_wb_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/cache_wb_ctrl.sv
// Cache line writeback engine: reads one block from the data array and writes it out as a single memory burst.
// Define CACHE_WB_BRESP_EN to wait for the write response (RESP state) and report err from b_resp.
module cache_wb_ctrl #(
  parameter int BLKIDX_BIT = 4,
  parameter int WRDIDX_BIT = 4,
  parameter int TAG_BIT    = 32 - BLKIDX_BIT - WRDIDX_BIT - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [BLKIDX_BIT-1:0] req_blkidx,
  input  logic [TAG_BIT-1:0]    req_tag,
  output logic [BLKIDX_BIT-1:0] arr_blkidx,
  output logic [WRDIDX_BIT-1:0] arr_wrdidx,
  input  logic [31:0]           arr_rdata,
  output logic                  aw_valid,
  input  logic                  aw_ready,
  output logic [31:0]           aw_addr,
  output logic [7:0]            aw_len,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [31:0]           w_data,
  output logic [3:0]            w_strb,
  output logic                  w_last,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [1:0]            b_resp,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int WRD_NUM = 1 << WRDIDX_BIT;

`ifdef CACHE_WB_BRESP_EN
  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
`else
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
`endif

  state_t                state_q, state_d;
  logic [BLKIDX_BIT-1:0] blk_q, blk_d;
  logic [31:0]           addr_q, addr_d;
  logic [WRDIDX_BIT-1:0] beat_q, beat_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

`ifndef CACHE_WB_BRESP_EN
  logic unused_b;
  assign unused_b = ^{b_valid, b_resp};
`endif

  assign aw_addr = addr_q;
  assign aw_len  = 8'(WRD_NUM - 1);
  assign w_data  = wdata_q;
  assign w_strb  = 4'hF;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign err     = err_q;

  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    addr_d     = addr_q;
    beat_d     = beat_q;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    req_ready  = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    w_last     = 1'b0;
    b_ready    = 1'b0;
    arr_blkidx = '0;
    arr_wrdidx = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          blk_d   = req_blkidx;
          addr_d  = {req_tag, req_blkidx, {WRDIDX_BIT{1'b0}}, 2'b00};
          beat_d  = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        aw_valid   = 1'b1;
        arr_blkidx = blk_q;
        // Word 0 is re-sampled every cycle so it is current when the address is accepted.
        wdata_d    = arr_rdata;
        if (aw_ready) state_d = DATA;
      end
      DATA: begin
        w_valid    = 1'b1;
        arr_blkidx = blk_q;
        // Look one word ahead so the next beat is ready in w_data right after the handshake.
        arr_wrdidx = beat_q + WRDIDX_BIT'(1);
        w_last     = (beat_q == WRDIDX_BIT'(WRD_NUM - 1));
        if (w_ready) begin
          if (!w_last) begin
            beat_d  = beat_q + WRDIDX_BIT'(1);
            wdata_d = arr_rdata;
          end else begin
`ifdef CACHE_WB_BRESP_EN
            state_d = RESP;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef CACHE_WB_BRESP_EN
      RESP: begin
        b_ready = 1'b1;
        if (b_valid) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = (b_resp != 2'b00);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      blk_q   <= '0;
      addr_q  <= '0;
      beat_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule
